// File: rtl/retire_unit.sv
// -----------------------------------------------------------------------------
// retire_unit
//
// Consumes the reorder buffer's commit slots, maintains the committed
// (architectural) register alias table and returns superseded physical tags to
// the free list. The first retired exception raises a one-cycle flush request.
// Retirement is then held off until recovery reports completion.
//
// Parameters:
//   ARCH_REGS  number of architectural registers (32, LEGv8)
//   PREG_W     physical tag width (7 -> 128 physical registers)
//   ZERO_REG   XZR index, never remapped
//   SLOTS      commit slots per cycle (slot 0 is the oldest)
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   commit_valid      per-slot commit strobe
//   commit_arch_rd    per-slot architectural destination
//   commit_phys_rd    per-slot physical destination
//   commit_exception  per-slot exception flag
//   flush_done        recovery complete, leaves EXC_WAIT
//   free_valid        per-slot free-list return strobe (registered)
//   free_preg         per-slot tag returned to the free list (registered)
//   rat_snapshot      flat committed RAT, entry i at [i*PREG_W +: PREG_W]
//   exc_flush         one-cycle pulse on the first retired exception
//   exc_slot          slot that raised the last exception (held)
//   retire_busy       high while waiting for recovery
//
// Optional feature (macro RETIRE_PERF_CNT_EN):
//   perf_retired      saturating count of slots retired without exception
//   perf_exc          saturating count of exc_flush pulses
// -----------------------------------------------------------------------------
module retire_unit #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PREG_W    = 7,
  parameter int unsigned ZERO_REG  = 31,
  parameter int unsigned SLOTS     = 2,
  localparam int unsigned SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SLOTS-1:0]              commit_valid,
  input  logic [SLOTS-1:0][4:0]         commit_arch_rd,
  input  logic [SLOTS-1:0][PREG_W-1:0]  commit_phys_rd,
  input  logic [SLOTS-1:0]              commit_exception,
  input  logic                          flush_done,
  output logic [SLOTS-1:0]              free_valid,
  output logic [SLOTS-1:0][PREG_W-1:0]  free_preg,
  output logic [ARCH_REGS*PREG_W-1:0]   rat_snapshot,
  output logic                          exc_flush,
  output logic [SLOT_W-1:0]             exc_slot,
  output logic                          retire_busy
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [15:0]                   perf_exc
`endif
);

  typedef enum logic {
    RUN,
    EXC_WAIT
  } state_t;

  state_t                               state_q;
  logic [ARCH_REGS-1:0][PREG_W-1:0]     rat_q;
  logic [ARCH_REGS-1:0][PREG_W-1:0]     rat_d;
  logic [SLOTS-1:0]                     free_valid_d;
  logic [SLOTS-1:0][PREG_W-1:0]         free_preg_d;
  logic                                 exc_hit;
  logic [SLOT_W-1:0]                    exc_idx;
  logic                                 squash;

`ifdef RETIRE_PERF_CNT_EN
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  logic [CNT_W-1:0]                     ret_cnt;
  logic [32:0]                          retired_sum;
`endif

  // Slots are walked oldest first against a working copy of the RAT, so a
  // younger slot sees the mapping an older slot wrote in the same cycle and
  // frees that tag instead of the stale registered one. Once an exception is
  // seen (or while waiting for recovery) every remaining slot is squashed:
  // its tag goes straight back to the free list and the RAT is left alone.
  always_comb begin
    rat_d        = rat_q;
    free_valid_d = '0;
    free_preg_d  = '0;
    exc_hit      = 1'b0;
    exc_idx      = '0;
    squash       = (state_q == EXC_WAIT);
`ifdef RETIRE_PERF_CNT_EN
    ret_cnt      = '0;
`endif
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (commit_valid[j]) begin
        free_valid_d[j] = 1'b1;
        if (squash) begin
          free_preg_d[j] = commit_phys_rd[j];
        end else if (commit_exception[j]) begin
          free_preg_d[j] = commit_phys_rd[j];
          squash         = 1'b1;
          exc_hit        = 1'b1;
          exc_idx        = SLOT_W'(j);
        end else if (commit_arch_rd[j] == 5'(ZERO_REG)) begin
          // XZR keeps its identity mapping; the allocated tag is simply unused.
          free_preg_d[j] = commit_phys_rd[j];
`ifdef RETIRE_PERF_CNT_EN
          ret_cnt        = ret_cnt + CNT_W'(1);
`endif
        end else begin
          free_preg_d[j]             = rat_d[commit_arch_rd[j]];
          rat_d[commit_arch_rd[j]]   = commit_phys_rd[j];
`ifdef RETIRE_PERF_CNT_EN
          ret_cnt                    = ret_cnt + CNT_W'(1);
`endif
        end
      end
    end
`ifdef RETIRE_PERF_CNT_EN
    retired_sum = {1'b0, perf_retired} + 33'(ret_cnt);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
      state_q    <= RUN;
      free_valid <= '0;
      free_preg  <= '0;
      exc_flush  <= 1'b0;
      exc_slot   <= '0;
    end else begin
      rat_q      <= rat_d;
      free_valid <= free_valid_d;
      free_preg  <= free_preg_d;
      exc_flush  <= exc_hit;
      if (exc_hit) begin
        exc_slot <= exc_idx;
      end
      // A commit in the same cycle as flush_done was already squashed above,
      // since squash is derived from the current state only.
      case (state_q)
        RUN:      if (exc_hit)    state_q <= EXC_WAIT;
        EXC_WAIT: if (flush_done) state_q <= RUN;
        default:                  state_q <= RUN;
      endcase
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_exc     <= '0;
    end else begin
      perf_retired <= retired_sum[32] ? '1 : retired_sum[31:0];
      if (exc_hit && (perf_exc != '1)) begin
        perf_exc <= perf_exc + 16'd1;
      end
    end
  end
`endif

  assign rat_snapshot = rat_q;
  assign retire_busy  = (state_q == EXC_WAIT);

endmodule

// File: tb/tb_retire_unit.sv
module tb_retire_unit;

  localparam int PW = 7;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [1:0]           commit_valid = '0;
  logic [1:0][4:0]      commit_arch_rd = '0;
  logic [1:0][PW-1:0]   commit_phys_rd = '0;
  logic [1:0]           commit_exception = '0;
  logic                 flush_done = 1'b0;
  logic [1:0]           free_valid;
  logic [1:0][PW-1:0]   free_preg;
  logic [32*PW-1:0]     rat_snapshot;
  logic                 exc_flush;
  logic                 exc_slot;
  logic                 retire_busy;
`ifdef RETIRE_PERF_CNT_EN
  logic [31:0]          perf_retired;
  logic [15:0]          perf_exc;
`endif

  retire_unit #(
    .ARCH_REGS (32),
    .PREG_W    (PW),
    .ZERO_REG  (31),
    .SLOTS     (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .commit_valid     (commit_valid),
    .commit_arch_rd   (commit_arch_rd),
    .commit_phys_rd   (commit_phys_rd),
    .commit_exception (commit_exception),
    .flush_done       (flush_done),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .rat_snapshot     (rat_snapshot),
    .exc_flush        (exc_flush),
    .exc_slot         (exc_slot),
    .retire_busy      (retire_busy)
`ifdef RETIRE_PERF_CNT_EN
    ,
    .perf_retired     (perf_retired),
    .perf_exc         (perf_exc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: committed mapping, recovery flag, expected outputs.
  int          m_rat[32];
  bit          m_busy;
  logic [1:0]  e_fv;
  logic [PW-1:0] e_fp[2];
  logic        e_flush;
  logic        e_slot;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_busy  = 1'b0;
    e_fv    = '0;
    e_fp[0] = '0;
    e_fp[1] = '0;
    e_flush = 1'b0;
    e_slot  = 1'b0;
  endtask

  function automatic logic [32*PW-1:0] pack_rat();
    logic [32*PW-1:0] r;
    for (int i = 0; i < 32; i++) r[i*PW +: PW] = PW'(m_rat[i]);
    return r;
  endfunction

  // Drive one commit cycle, advance the model, and return #1 after the edge
  // with inputs idle again.
  task automatic apply(input logic [1:0] v, input int a0, input int p0, input bit x0,
                       input int a1, input int p1, input bit x1, input bit fd);
    int a[2];
    int p[2];
    bit x[2];
    int boundary;
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1; x[0] = x0; x[1] = x1;
    commit_valid     = v;
    commit_arch_rd[0] = 5'(a0);
    commit_arch_rd[1] = 5'(a1);
    commit_phys_rd[0] = PW'(p0);
    commit_phys_rd[1] = PW'(p1);
    commit_exception = {x1, x0};
    flush_done       = fd;

    // Slots from the boundary onward only return their tag; nothing retires
    // while recovering, otherwise the first excepting slot is the boundary.
    boundary = m_busy ? 0 : 2;
    if (!m_busy)
      for (int s = 1; s >= 0; s--) if (v[s] && x[s]) boundary = s;
    e_fv    = v;
    e_flush = 1'b0;
    for (int s = 0; s < 2; s++) begin
      e_fp[s] = '0;
      if (v[s]) begin
        if (s >= boundary || a[s] == 31) e_fp[s] = PW'(p[s]);
        else begin
          e_fp[s]     = PW'(m_rat[a[s]]);
          m_rat[a[s]] = p[s];
        end
      end
    end
    if (!m_busy && boundary < 2) begin
      e_flush = 1'b1;
      e_slot  = boundary[0];
      m_busy  = 1'b1;
    end else if (m_busy && fd) begin
      m_busy = 1'b0;
    end

    @(posedge clk);
    #1;
    commit_valid     = '0;
    commit_exception = '0;
    flush_done       = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    checks++; if (free_valid !== 2'b00) begin errors++; $display("FAIL reset_free_valid: got %b expected 00", free_valid); end
    checks++; if (exc_flush !== 1'b0) begin errors++; $display("FAIL reset_exc_flush: got %b expected 0", exc_flush); end
    checks++; if (exc_slot !== 1'b0) begin errors++; $display("FAIL reset_exc_slot: got %b expected 0", exc_slot); end
    checks++; if (retire_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", retire_busy); end
    checks++; if (rat_snapshot !== pack_rat()) begin errors++; $display("FAIL reset_rat: got %h expected %h", rat_snapshot, pack_rat()); end
    checks++; if (free_preg !== '0) begin errors++; $display("FAIL reset_free_preg: got %h expected 0", free_preg); end
  endtask

  task automatic test_commit_basic();
    apply(2'b01, 3, 40, 0, 0, 0, 0, 0);
    checks++; if (free_valid !== 2'b01) begin errors++; $display("FAIL single_fv: got %b expected 01", free_valid); end
    checks++; if (free_preg[0] !== PW'(3)) begin errors++; $display("FAIL single_fp0: got %0d expected 3", free_preg[0]); end
    checks++; if (rat_snapshot[3*PW +: PW] !== PW'(40)) begin errors++; $display("FAIL single_rat3: got %0d expected 40", rat_snapshot[3*PW +: PW]); end

    apply(2'b11, 5, 41, 0, 7, 42, 0, 0);
    checks++; if (free_valid !== 2'b11) begin errors++; $display("FAIL dual_fv: got %b expected 11", free_valid); end
    checks++; if (free_preg[0] !== PW'(5) || free_preg[1] !== PW'(7)) begin errors++; $display("FAIL dual_fp: got %0d/%0d expected 5/7", free_preg[0], free_preg[1]); end
    checks++; if (rat_snapshot[5*PW +: PW] !== PW'(41) || rat_snapshot[7*PW +: PW] !== PW'(42)) begin errors++; $display("FAIL dual_rat: got %0d/%0d expected 41/42", rat_snapshot[5*PW +: PW], rat_snapshot[7*PW +: PW]); end

    apply(2'b11, 9, 43, 0, 9, 44, 0, 0);
    checks++; if (free_preg[0] !== PW'(9) || free_preg[1] !== PW'(43)) begin errors++; $display("FAIL samedst_fp: got %0d/%0d expected 9/43", free_preg[0], free_preg[1]); end
    checks++; if (rat_snapshot[9*PW +: PW] !== PW'(44)) begin errors++; $display("FAIL samedst_rat9: got %0d expected 44", rat_snapshot[9*PW +: PW]); end

    apply(2'b01, 31, 45, 0, 0, 0, 0, 0);
    checks++; if (rat_snapshot[31*PW +: PW] !== PW'(31)) begin errors++; $display("FAIL xzr_rat31: got %0d expected 31", rat_snapshot[31*PW +: PW]); end
    checks++; if (free_valid !== 2'b01 || free_preg[0] !== PW'(45)) begin errors++; $display("FAIL xzr_fp0: got %b/%0d expected 01/45", free_valid, free_preg[0]); end
  endtask

  task automatic test_exception_flow();
    apply(2'b11, 2, 46, 1, 4, 47, 0, 0);
    checks++; if (rat_snapshot[2*PW +: PW] !== PW'(2) || rat_snapshot[4*PW +: PW] !== PW'(4)) begin errors++; $display("FAIL exc0_rat: got %0d/%0d expected 2/4", rat_snapshot[2*PW +: PW], rat_snapshot[4*PW +: PW]); end
    checks++; if (free_valid !== 2'b11 || free_preg[0] !== PW'(46) || free_preg[1] !== PW'(47)) begin errors++; $display("FAIL exc0_fp: got %b %0d/%0d expected 11 46/47", free_valid, free_preg[0], free_preg[1]); end
    checks++; if (exc_flush !== 1'b1 || exc_slot !== 1'b0 || retire_busy !== 1'b1) begin errors++; $display("FAIL exc0_flags: got flush=%b slot=%b busy=%b expected 1 0 1", exc_flush, exc_slot, retire_busy); end

    apply(2'b01, 6, 48, 0, 0, 0, 0, 0);
    checks++; if (free_valid !== 2'b01 || free_preg[0] !== PW'(48)) begin errors++; $display("FAIL wait_fp: got %b/%0d expected 01/48", free_valid, free_preg[0]); end
    checks++; if (rat_snapshot[6*PW +: PW] !== PW'(6)) begin errors++; $display("FAIL wait_rat6: got %0d expected 6", rat_snapshot[6*PW +: PW]); end
    checks++; if (exc_flush !== 1'b0 || retire_busy !== 1'b1) begin errors++; $display("FAIL wait_flags: got flush=%b busy=%b expected 0 1", exc_flush, retire_busy); end

    apply(2'b00, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (retire_busy !== 1'b0) begin errors++; $display("FAIL recover_busy: got %b expected 0", retire_busy); end

    apply(2'b01, 6, 49, 0, 0, 0, 0, 0);
    checks++; if (rat_snapshot[6*PW +: PW] !== PW'(49) || free_preg[0] !== PW'(6)) begin errors++; $display("FAIL resume: got rat6=%0d fp0=%0d expected 49/6", rat_snapshot[6*PW +: PW], free_preg[0]); end
  endtask

  task automatic test_back_to_back();
    // Slot 1 excepts while slot 0 retires normally.
    apply(2'b11, 10, 50, 0, 11, 51, 1, 0);
    checks++; if (rat_snapshot[10*PW +: PW] !== PW'(50) || rat_snapshot[11*PW +: PW] !== PW'(11)) begin errors++; $display("FAIL exc1_rat: got %0d/%0d expected 50/11", rat_snapshot[10*PW +: PW], rat_snapshot[11*PW +: PW]); end
    checks++; if (exc_flush !== 1'b1 || exc_slot !== 1'b1 || free_preg[1] !== PW'(51)) begin errors++; $display("FAIL exc1_flags: got flush=%b slot=%b fp1=%0d expected 1 1 51", exc_flush, exc_slot, free_preg[1]); end

    // A further excepting commit while waiting must not pulse again.
    apply(2'b01, 15, 55, 1, 0, 0, 0, 0);
    checks++; if (exc_flush !== 1'b0 || exc_slot !== 1'b1 || retire_busy !== 1'b1) begin errors++; $display("FAIL hold: got flush=%b slot=%b busy=%b expected 0 1 1", exc_flush, exc_slot, retire_busy); end

    // Commit in the same cycle as flush_done is still squashed.
    apply(2'b01, 12, 52, 0, 0, 0, 0, 1);
    checks++; if (rat_snapshot[12*PW +: PW] !== PW'(12) || free_preg[0] !== PW'(52) || retire_busy !== 1'b0) begin errors++; $display("FAIL fd_commit: got rat12=%0d fp0=%0d busy=%b expected 12 52 0", rat_snapshot[12*PW +: PW], free_preg[0], retire_busy); end

    // Both slots except: slot 0 wins.
    apply(2'b11, 13, 53, 1, 14, 54, 1, 0);
    checks++; if (exc_slot !== 1'b0 || exc_flush !== 1'b1 || rat_snapshot[14*PW +: PW] !== PW'(14)) begin errors++; $display("FAIL both_exc: got slot=%b flush=%b rat14=%0d expected 0 1 14", exc_slot, exc_flush, rat_snapshot[14*PW +: PW]); end
    apply(2'b00, 0, 0, 0, 0, 0, 0, 1);

    // flush_done in RUN has no effect.
    apply(2'b01, 16, 56, 0, 0, 0, 0, 1);
    checks++; if (retire_busy !== 1'b0 || rat_snapshot[16*PW +: PW] !== PW'(56)) begin errors++; $display("FAIL fd_in_run: got busy=%b rat16=%0d expected 0 56", retire_busy, rat_snapshot[16*PW +: PW]); end
  endtask

  task automatic test_random();
    logic [1:0] v;
    int a0, a1;
    bit fd;
    for (int n = 0; n < 400; n++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 9) == 0) ? 31 : ($urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
      fd = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      apply(v, a0, $urandom_range(0, 127), $urandom_range(0, 15) == 0,
               a1, $urandom_range(0, 127), $urandom_range(0, 15) == 0, fd);
      checks++; if (free_valid !== e_fv) begin errors++; $display("FAIL rnd_fv[%0d]: got %b expected %b", n, free_valid, e_fv); end
      for (int s = 0; s < 2; s++)
        if (e_fv[s]) begin
          checks++; if (free_preg[s] !== e_fp[s]) begin errors++; $display("FAIL rnd_fp%0d[%0d]: got %0d expected %0d", s, n, free_preg[s], e_fp[s]); end
        end
      checks++; if (rat_snapshot !== pack_rat()) begin errors++; $display("FAIL rnd_rat[%0d]: got %h expected %h", n, rat_snapshot, pack_rat()); end
      checks++; if (exc_flush !== e_flush || exc_slot !== e_slot) begin errors++; $display("FAIL rnd_exc[%0d]: got %b/%b expected %b/%b", n, exc_flush, exc_slot, e_flush, e_slot); end
      checks++; if (retire_busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, retire_busy, m_busy); end
    end
  endtask

  task automatic test_reset_mid();
    apply(2'b11, 1, 100, 0, 2, 101, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (rat_snapshot !== pack_rat()) begin errors++; $display("FAIL midreset_rat: got %h expected %h", rat_snapshot, pack_rat()); end
    checks++; if (free_valid !== 2'b00 || retire_busy !== 1'b0) begin errors++; $display("FAIL midreset_out: got fv=%b busy=%b expected 00 0", free_valid, retire_busy); end
    #2;
    reset = 1'b0;
    apply(2'b01, 1, 102, 0, 0, 0, 0, 0);
    checks++; if (free_preg[0] !== PW'(1) || rat_snapshot[1*PW +: PW] !== PW'(102)) begin errors++; $display("FAIL postreset: got fp0=%0d rat1=%0d expected 1 102", free_preg[0], rat_snapshot[1*PW +: PW]); end
  endtask

  initial begin
    #12;
    test_reset();
    reset = 1'b0;
    test_commit_basic();
    test_exception_flow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
- Sits directly downstream of the reorder buffer and consumes its dual commit slots: commit valid flag, architectural destination, physical destination and exception flag per slot.
- Maintains the committed (architectural) register alias table (RAT) mapping the 32 LEGv8 registers to physical tags.
- Returns superseded physical tags to the free list.
- Raises a one-shot exception/flush request and holds off further retirement until recovery completes.

Parameters:
- ARCH_REGS, 32, number of architectural registers.
- PREG_W, $clog2(core_pkg::PREGS), physical tag width.
- ZERO_REG, 31, XZR index; never remapped.
- SLOTS, core_pkg::ISSUE_WIDTH (=2), commit slots per cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  SLOTS  per-slot commit strobe from ROB.
- commit_arch_rd  in  SLOTS x 5  architectural destination per slot.
- commit_phys_rd  in  SLOTS x PREG_W  physical destination per slot.
- commit_exception  in  SLOTS  per-slot exception flag.
- flush_done  in  1  recovery complete; releases the EXC_WAIT state.
- free_valid  out  SLOTS  per-slot free-list return strobe.
- free_preg  out  SLOTS x PREG_W  tag returned to free list.
- rat_snapshot  out  ARCH_REGS x PREG_W  flat committed RAT; entry i at bits [i*PREG_W +: PREG_W].
- exc_flush  out  1  one-cycle pulse on first retired exception.
- exc_slot  out  1  slot index that raised the exception; held until the next exception.
- retire_busy  out  1  high while in EXC_WAIT.

Behaviour:
- Reset (async): RAT[i]=i for all i. free_valid=0. free_preg=0. exc_flush=0. exc_slot=0. State=RUN.
- All outputs are registered. Free returns appear 1 cycle after the commit cycle. rat_snapshot reflects the RAT register, so an update is visible the cycle after commit.
- Slot ordering: slot 0 is older than slot 1. Slots are processed in order within a cycle.
- RUN state, per valid slot j, no exception, arch_rd != ZERO_REG:
  - free_preg[j] = current mapping of arch_rd, including any same-cycle slot-0 update.
  - RAT[arch_rd] <= phys_rd.
  - free_valid[j] = 1.
- Same-cycle same-destination: if both slots are valid, share arch_rd and neither is excepting:
  - slot 1 frees slot 0's phys_rd (not the old RAT value);
  - slot 0 frees the old RAT value;
  - final RAT = slot 1 phys_rd.
- arch_rd == ZERO_REG: RAT unchanged. phys_rd freed directly (free_valid[j]=1, free_preg[j]=phys_rd).
- Exception on slot j in RUN:
  - slot j does not update the RAT; its phys_rd is freed;
  - if j=0, slot 1 is treated as younger/squashed: phys_rd freed if valid, no RAT update;
  - exc_flush=1 for one cycle; exc_slot=j; state -> EXC_WAIT.
  - Exceptions on both slots: slot 0 wins.
- EXC_WAIT:
  - any commit_valid slot: phys_rd freed, no RAT update, no further exc_flush.
  - flush_done=1 -> RUN next cycle. A commit arriving in the same cycle as flush_done is still handled as EXC_WAIT.
- flush_done in RUN: ignored.
- No backpressure. The free list must accept SLOTS returns per cycle.
- Reset mid-operation: RAT is restored to identity immediately; pending free returns are dropped.

Optional Feature:
- Macro RETIRE_PERF_CNT_EN.
- Defined: adds outputs perf_retired (32 bit) and perf_exc (16 bit), both reset to 0 and saturating at max.
  - perf_retired += number of slots that updated the RAT or targeted ZERO_REG without exception, in RUN only.
  - perf_exc += 1 per exc_flush pulse.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then single commit slot0 arch 3, phys 40 -> next cycle free_valid=01, free_preg[0]=3, RAT[3]=40.
- Dual commit arch 5/phys 41 and arch 7/phys 42 -> free_preg={7,5} (slot1, slot0), RAT[5]=41, RAT[7]=42.
- Dual commit same arch 9: slot0 phys 43, slot1 phys 44 -> free_preg[0]=9, free_preg[1]=43, RAT[9]=44.
- Commit arch 31 phys 45 -> RAT[31] stays 31, free_preg[0]=45.
- Slot0 exception arch 2 phys 46 with slot1 valid arch 4 phys 47 -> RAT[2]/RAT[4] unchanged, frees 46 and 47, exc_flush pulse, exc_slot=0, retire_busy=1.
- In EXC_WAIT, commit arch 6 phys 48 -> freed, RAT[6]=6; assert flush_done -> retire_busy=0 next cycle; following commit updates RAT normally.
